// File: rtl/alu_ctrl.sv
// 6502 ALU sequencer and processor status register.
// Runs IDLE -> EXEC -> FLAGS per request, strobes the ALU and folds its status into P.
module alu_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic       req_dest,
  input  logic       alu_cout,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  input  logic       alu_neg,
  output logic       sums,
  output logic       subs,
  output logic       ands,
  output logic       eors,
  output logic       ors,
  output logic       shftr,
  output logic       shftcr,
  output logic       decEn,
  output logic       cin,
  output logic       adloa,
  output logic       sboa,
  output logic       alu_reset,
  output logic       done,
  output logic       illegal,
  input  logic       p_load,
  input  logic [7:0] p_in,
  input  logic       sec,
  input  logic       clc,
  input  logic       sed,
  input  logic       cld,
  input  logic       sei,
  input  logic       cli,
  input  logic       clv,
  output logic [7:0] p_out
);

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_EOR = 4'd3;
  localparam logic [3:0] OP_ORA = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FLAGS = 2'd2
  } state_e;

  state_e     state_q;
  logic [3:0] op_q;
  logic       dest_q;
  logic [6:0] strb_q;
  logic       adloa_q;
  logic       sboa_q;
  logic       done_q;
  logic       illegal_q;
  logic [7:0] p_q;
  logic [7:0] p_d;

  // Strobe order {sums, subs, ands, eors, ors, shftr, shftcr}; CMP shares the subtractor.
  function automatic logic [6:0] op_strobes(input logic [3:0] op);
    logic [6:0] s;
    case (op)
      OP_ADC:  s = 7'b100_0000;
      OP_SBC:  s = 7'b010_0000;
      OP_CMP:  s = 7'b010_0000;
      OP_AND:  s = 7'b001_0000;
      OP_EOR:  s = 7'b000_1000;
      OP_ORA:  s = 7'b000_0100;
      OP_LSR:  s = 7'b000_0010;
      OP_ROR:  s = 7'b000_0001;
      default: s = 7'b000_0000;
    endcase
    return s;
  endfunction

  // Sequencer state and all handshake-derived registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= 4'd0;
      dest_q    <= 1'b0;
      strb_q    <= 7'd0;
      adloa_q   <= 1'b0;
      sboa_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      strb_q    <= 7'd0;
      adloa_q   <= 1'b0;
      sboa_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            dest_q <= req_dest;
            if (req_op[3]) begin
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end else begin
              state_q <= ST_EXEC;
              strb_q  <= op_strobes(req_op);
            end
          end
        end
        ST_EXEC: begin
          state_q <= ST_FLAGS;
          done_q  <= 1'b1;
          if (op_q != OP_CMP) begin
            adloa_q <= dest_q;
            sboa_q  <= ~dest_q;
          end
        end
        ST_FLAGS: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Next P: FLAGS capture, then set/clear pulses (set wins), then p_load on top.
  always_comb begin
    p_d = p_q;
    if (state_q == ST_FLAGS) begin
      case (op_q)
        OP_ADC, OP_SBC: begin
          p_d[0] = alu_cout;
          p_d[1] = alu_zero;
          p_d[6] = alu_ovf;
          p_d[7] = alu_neg;
        end
        OP_AND, OP_EOR, OP_ORA: begin
          p_d[1] = alu_zero;
          p_d[7] = alu_neg;
        end
        OP_LSR, OP_ROR, OP_CMP: begin
          p_d[0] = alu_cout;
          p_d[1] = alu_zero;
          p_d[7] = alu_neg;
        end
        default: p_d = p_q;
      endcase
    end else begin
      p_d = p_q;
    end
    p_d[0] = sec ? 1'b1 : (clc ? 1'b0 : p_d[0]);
    p_d[2] = sei ? 1'b1 : (cli ? 1'b0 : p_d[2]);
    p_d[3] = sed ? 1'b1 : (cld ? 1'b0 : p_d[3]);
    p_d[6] = clv ? 1'b0 : p_d[6];
    p_d    = p_load ? {p_in[7:6], 1'b1, p_in[4:0]} : p_d;
    p_d[5] = 1'b1;
  end

  // Processor status register.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= 8'h24;
    end else begin
      p_q <= p_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE) & ~reset;
  assign {sums, subs, ands, eors, ors, shftr, shftcr} = strb_q;
  // sums is only ever raised for ADC, so decimal mode never reaches SBC.
  assign decEn     = strb_q[6] & p_q[3];
  assign cin       = p_q[0];
  assign adloa     = adloa_q;
  assign sboa      = sboa_q;
  assign alu_reset = reset;
  assign done      = done_q;
  assign illegal   = illegal_q;
  assign p_out     = p_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed scoreboard bench for alu_ctrl: expected P/enables queued at issue, checked at done.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic       req_dest;
  logic       alu_cout, alu_zero, alu_ovf, alu_neg;
  logic       sums, subs, ands, eors, ors, shftr, shftcr;
  logic       decEn, cin, adloa, sboa, alu_reset, done, illegal;
  logic       p_load;
  logic [7:0] p_in;
  logic       sec, clc, sed, cld, sei, cli, clv;
  logic [7:0] p_out;

  typedef struct {
    logic [7:0] p;
    logic       ill;
    logic       adl;
    logic       sb;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_dest(req_dest),
    .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_neg(alu_neg),
    .sums(sums), .subs(subs), .ands(ands), .eors(eors), .ors(ors), .shftr(shftr), .shftcr(shftcr),
    .decEn(decEn), .cin(cin), .adloa(adloa), .sboa(sboa), .alu_reset(alu_reset),
    .done(done), .illegal(illegal),
    .p_load(p_load), .p_in(p_in),
    .sec(sec), .clc(clc), .sed(sed), .cld(cld), .sei(sei), .cli(cli), .clv(clv),
    .p_out(p_out)
  );

  function automatic logic [7:0] strobes();
    return {1'b0, sums, subs, ands, eors, ors, shftr, shftcr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic dest,
                        input logic co, input logic zr, input logic ov, input logic ng,
                        input logic [7:0] exp_strb, input logic exp_dec, input logic [7:0] exp_p,
                        input logic fl_load, input logic [7:0] fl_pin, input logic fl_clc);
    exp_t e;
    int   lat;
    bit   seen;
    e.p   = exp_p;
    e.ill = op[3];
    e.adl = (!op[3] && op != 4'd7) ? dest : 1'b0;
    e.sb  = (!op[3] && op != 4'd7) ? ~dest : 1'b0;
    e.lat = op[3] ? 0 : 1;
    req_valid = 1'b1; req_op = op; req_dest = dest;
    alu_cout = co; alu_zero = zr; alu_ovf = ov; alu_neg = ng;
    check({tag, "_ready"}, req_ready, 8'd1);
    sb_q.push_back(e);
    tick();
    if (!op[3]) begin
      check({tag, "_exec_strb"}, strobes(), exp_strb);
      check({tag, "_exec_dec"}, decEn, exp_dec);
      check({tag, "_exec_busy"}, req_ready, 8'd0);
    end
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 6) begin
      if (done) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    req_valid = 1'b0;
    check({tag, "_done_seen"}, seen, 8'd1);
    e = sb_q.pop_front();
    if (seen) begin
      check({tag, "_lat"}, lat[7:0], e.lat[7:0]);
      check({tag, "_illegal"}, illegal, e.ill);
      check({tag, "_adloa"}, adloa, e.adl);
      check({tag, "_sboa"}, sboa, e.sb);
      check({tag, "_flags_strb"}, strobes(), 8'd0);
      check({tag, "_flags_dec"}, decEn, 8'd0);
      check({tag, "_done_ready"}, req_ready, e.ill);
      p_load = fl_load; p_in = fl_pin; clc = fl_clc;
      tick();
      p_load = 1'b0; clc = 1'b0;
      check({tag, "_p"}, p_out, e.p);
      check({tag, "_done_drop"}, done, 8'd0);
      check({tag, "_after_ready"}, req_ready, 8'd1);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_dest = 1'b0;
    alu_cout = 1'b0; alu_zero = 1'b0; alu_ovf = 1'b0; alu_neg = 1'b0;
    p_load = 1'b0; p_in = 8'h00;
    sec = 1'b0; clc = 1'b0; sed = 1'b0; cld = 1'b0; sei = 1'b0; cli = 1'b0; clv = 1'b0;
    tick(); tick(); tick();
    check("rst_ready", req_ready, 8'd0);
    check("rst_alu_reset", alu_reset, 8'd1);
    check("rst_strb", strobes(), 8'd0);
    reset = 1'b0;
    #1;
    check("rst_p", p_out, 8'h24);
    check("rst_cin", cin, 8'd0);
    check("rst_done", {done, illegal, adloa, sboa, decEn}, 8'd0);
    check("rst_ready_rel", req_ready, 8'd1);
    check("rst_alu_reset_rel", alu_reset, 8'd0);

    run_op("adc_bin", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'hE4, 1'b0, 8'h00, 1'b0);

    p_load = 1'b1; p_in = 8'h04; tick(); p_load = 1'b0;
    check("pload_bit5", p_out, 8'h24);
    sed = 1'b1; tick(); sed = 1'b0;
    check("sed", p_out, 8'h2C);

    run_op("adc_dec", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 1'b1, 8'h2D, 1'b0, 8'h00, 1'b0);
    check("cin_follows_c", cin, 8'd1);
    run_op("sbc_dec", 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 1'b0, 8'h2E, 1'b0, 8'h00, 1'b0);

    p_load = 1'b1; p_in = 8'h04; tick(); p_load = 1'b0;
    check("pload_clear", p_out, 8'h24);

    run_op("cmp", 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 8'h27, 1'b0, 8'h00, 1'b0);
    run_op("and", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);
    run_op("eor", 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 8'h27, 1'b0, 8'h00, 1'b0);
    run_op("ora", 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 1'b0, 8'h25, 1'b0, 8'h00, 1'b0);
    run_op("lsr", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 8'h24, 1'b0, 8'h00, 1'b0);
    run_op("ror", 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);
    run_op("ill9", 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);
    run_op("ill15", 4'd15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);

    clc = 1'b1; tick(); clc = 1'b0;
    check("clc", p_out, 8'hA4);
    sec = 1'b1; clc = 1'b1; tick(); sec = 1'b0; clc = 1'b0;
    check("sec_wins", p_out, 8'hA5);
    cli = 1'b1; tick(); cli = 1'b0;
    check("cli", p_out, 8'hA1);
    sei = 1'b1; cli = 1'b1; tick(); sei = 1'b0; cli = 1'b0;
    check("sei_wins", p_out, 8'hA5);
    sed = 1'b1; cld = 1'b1; tick(); sed = 1'b0; cld = 1'b0;
    check("sed_wins", p_out, 8'hAD);
    cld = 1'b1; clv = 1'b1; tick(); cld = 1'b0; clv = 1'b0;
    check("cld_clv", p_out, 8'hA5);

    run_op("flags_ovr", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0, 8'h20, 1'b1, 8'h00, 1'b1);

    req_valid = 1'b1; req_op = 4'd0; req_dest = 1'b0;
    tick();
    req_valid = 1'b0;
    check("abort_exec_strb", strobes(), 8'h40);
    reset = 1'b1;
    tick();
    check("abort_strb", strobes(), 8'd0);
    check("abort_done", done, 8'd0);
    check("abort_oe", {adloa, sboa}, 8'd0);
    check("abort_p", p_out, 8'h24);
    check("abort_ready_in_rst", req_ready, 8'd0);
    check("abort_alu_reset", alu_reset, 8'd1);
    reset = 1'b0;
    #1;
    check("abort_ready", req_ready, 8'd1);
    tick();
    check("abort_no_done", done, 8'd0);
    check("abort_idle_strb", strobes(), 8'd0);
    check("abort_p_hold", p_out, 8'h24);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
